// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches to imem, buffers the
// returned words and presents {inst, pc, fault} to decode. Latency: rsp_valid at N -> inst_valid at N+1.
// Backpressure: requests are credit-limited to BUF_DEPTH in-flight plus buffered; decode stalls hold the head.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr     word fetch request (addr bits[1:0] always 0)
//   imem_rsp_valid/data/err       in-order response, no backpressure
//   redirect_valid/pc             flush buffered and in-flight fetches, restart at redirect_pc
//   inst_valid/ready, inst_o,     buffered instruction to decode
//   inst_pc_o, inst_fault

// Small synchronous FIFO used for both the instruction buffer and the request pc tags.
// Latency: push visible at head the cycle after; head is a registered entry (no comb path from push_data).
// Backpressure: none internally; the caller must never push when full or pop when empty.
module inst_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// Fetch stage top: PC sequencing, credit-limited request issue, response drop after redirect.
// Latency: rsp_valid at N -> inst_valid at N+1; first request one cycle after reset release.
// Backpressure: decode stall fills the buffer, which withholds request credits.
module inst_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  output logic        inst_fault
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  typedef struct packed {
    logic        fault;
    logic [63:0] pc;
    logic [31:0] inst;
  } buf_entry_t;

  logic [1:0]    state;
  logic [63:0]   fetch_pc;
  logic [CW-1:0] drop_cnt;

  logic [CW-1:0] buf_count;
  logic [CW-1:0] tag_count;
  buf_entry_t    buf_head;
  buf_entry_t    buf_push_dat;
  logic [63:0]   tag_head;

  logic          pop;
  logic          accept;
  logic          rsp_live;
  logic          rsp_keep;
  logic [CW:0]   credit_used;
  logic [CW-1:0] out_next;

  // Outstanding requests are exactly the entries in the pc-tag FIFO.
  assign pop         = inst_valid & inst_ready;
  assign credit_used = {1'b0, tag_count} + {1'b0, buf_count - CW'(pop)};

  assign imem_req_valid = (state == S_RUN) && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign rsp_live = imem_rsp_valid && (tag_count != '0);
  // A response in the redirect cycle or owed to an earlier redirect never reaches the buffer.
  assign rsp_keep = rsp_live && !redirect_valid && (drop_cnt == '0);
  assign out_next = tag_count + CW'(accept) - CW'(rsp_live);

  always_comb begin
    buf_push_dat       = '0;
    buf_push_dat.fault = imem_rsp_err;
    buf_push_dat.pc    = tag_head;
    buf_push_dat.inst  = imem_rsp_data;
  end

  inst_fetch_fifo #(
    .WIDTH ($bits(buf_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_push_dat),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // Tags are never flushed: each outstanding request still returns a response that must pop its tag.
  inst_fetch_fifo #(
    .WIDTH (64),
    .DEPTH (BUF_DEPTH)
  ) u_tag (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_live),
    .head      (tag_head),
    .count     (tag_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      if (redirect_valid) begin
        state    <= S_RUN;
        // Everything still in flight after this cycle belongs to the old stream.
        drop_cnt <= out_next;
        fetch_pc <= redirect_pc & ~64'h3;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 64'd4;
        end
        if (rsp_live && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        case (state)
          S_BOOT:  state <= S_RUN;
          S_RUN:   if (rsp_keep && imem_rsp_err) state <= S_FAULT;
          default: state <= state;
        endcase
      end
    end
  end

  assign inst_valid = (buf_count != '0);
  assign inst_o     = buf_head.inst;
  assign inst_pc_o  = buf_head.pc;
  assign inst_fault = buf_head.fault;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle, imem responder,
// and directed scenarios with hand-computed literal expectations.
module tb_inst_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_fault;

  inst_fetch #(.RESET_PC(64'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
    int          cyc;
  } ent_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  // Responder controls and shared observation state
  logic        rsp_en      = 1'b1;
  logic        stray_pulse = 1'b0;
  logic [63:0] err_addr    = '1;
  logic        acc_seen    = 1'b0;
  logic [63:0] acc_addr    = '0;
  logic        rst_seen    = 1'b0;
  logic [63:0] pend[$];

  // Model state: the spec's rules expressed with queues
  bit          known = 0;
  int          cyc   = 0;
  int          m_state;            // 0 boot, 1 run, 2 fault
  logic [63:0] m_pc;
  logic [63:0] m_outq[$];
  int          m_drop;
  ent_t        m_buf[$];
  ent_t        xq[$];              // log of completed transfers
  int          acc_cnt = 0;
  int          req_cnt = 0;

  always @(negedge clk) begin
    bit          pop;
    bit          exp_req;
    bit          acc;
    bit          rsp;
    int          used;
    logic [63:0] tag;
    ent_t        e;
    cyc++;
    acc_seen = known && ((imem_req_valid & imem_req_ready) === 1'b1);
    acc_addr = imem_req_addr;
    rst_seen = rst;
    if (known) begin
      pop     = (m_buf.size() > 0) && inst_ready;
      used    = m_outq.size() + m_buf.size() - (pop ? 1 : 0);
      exp_req = (m_state == 1) && (used < DEPTH);
      chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
      chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", 64'(inst_valid), 64'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        chk("inst_o", 64'(inst_o), 64'(m_buf[0].inst));
        chk("inst_pc_o", inst_pc_o, m_buf[0].pc);
        chk("inst_fault", 64'(inst_fault), 64'(m_buf[0].fault));
      end
      if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
        e = '{inst_o, inst_pc_o, inst_fault, cyc};
        xq.push_back(e);
      end
      if (acc_seen) acc_cnt++;
      if (imem_req_valid === 1'b1) req_cnt++;
    end
    if (rst) begin
      known   = 1;
      m_state = 0;
      m_pc    = 64'h0;
      m_drop  = 0;
      m_outq.delete();
      m_buf.delete();
    end else if (known) begin
      acc = exp_req && imem_req_ready;
      rsp = imem_rsp_valid && (m_outq.size() > 0);
      if (pop) void'(m_buf.pop_front());
      if (rsp) begin
        tag = m_outq.pop_front();
        if (redirect_valid) begin
          // discarded by the redirect
        end else if (m_drop > 0) begin
          m_drop--;
        end else begin
          e = '{imem_rsp_data, tag, imem_rsp_err, 0};
          m_buf.push_back(e);
          if (imem_rsp_err && m_state == 1) m_state = 2;
        end
      end
      if (acc) begin
        m_outq.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
      if (redirect_valid) begin
        m_buf.delete();
        m_drop  = m_outq.size();
        m_pc    = {redirect_pc[63:2], 2'b00};
        m_state = 1;
      end else if (m_state == 0) begin
        m_state = 1;
      end
    end
  end

  // imem responder: one-cycle latency when enabled, in order
  always @(posedge clk) begin
    logic [63:0] a;
    #2;
    if (acc_seen) pend.push_back(acc_addr);
    if (rst_seen) pend.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    if (stray_pulse) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      stray_pulse    = 1'b0;
    end else if (rsp_en && pend.size() > 0) begin
      a = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(a);
      imem_rsp_err   = (a == err_addr);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_xfer(input int want, input string name);
    int k = 0;
    while (xq.size() < want && k < 40) begin
      step(1);
      k++;
    end
    chk(name, 64'(xq.size() >= want), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 64'h0);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_inst_o"}, 64'(inst_o), 64'd0);
    chk({tag, "_inst_pc"}, inst_pc_o, 64'h0);
    chk({tag, "_inst_fault"}, 64'(inst_fault), 64'd0);
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] last_pc;
    logic [63:0] a0;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    step(3);
    check_reset_outputs("reset");

    // 1: streaming, back-to-back transfers from RESET_PC
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    xq.delete();
    wait_xfer(4, "t1_xfers");
    for (int i = 0; i < 4 && i < xq.size(); i++) begin
      chk("t1_pc", xq[i].pc, 64'(4 * i));
      chk("t1_inst", 64'(xq[i].inst), 64'(word_of(64'(4 * i))));
      chk("t1_fault", 64'(xq[i].fault), 64'd0);
      if (i > 0) chk("t1_b2b", 64'(xq[i].cyc - xq[i-1].cyc), 64'd1);
    end

    // 2: decode stall -> exactly DEPTH accepts, head held, then resume without loss
    imem_req_ready = 1'b0;
    step(6);
    last_pc = (xq.size() > 0) ? xq[xq.size()-1].pc : 64'h0;
    inst_ready     = 1'b0;
    acc_cnt        = 0;
    imem_req_ready = 1'b1;
    step(8);
    chk("t2_accepts", 64'(acc_cnt), 64'd2);
    chk("t2_req_valid_low", 64'(imem_req_valid), 64'd0);
    chk("t2_head_valid", 64'(inst_valid), 64'd1);
    chk("t2_head_pc", inst_pc_o, last_pc + 64'd4);
    chk("t2_head_inst", 64'(inst_o), 64'(word_of(last_pc + 64'd4)));
    xq.delete();
    inst_ready = 1'b1;
    wait_xfer(4, "t2_resume");
    for (int i = 0; i < 4 && i < xq.size(); i++)
      chk("t2_seq_pc", xq[i].pc, last_pc + 64'(4 * (i + 1)));

    // 3: redirect with two requests in flight
    imem_req_ready = 1'b0;
    step(6);
    rsp_en         = 1'b0;
    acc_cnt        = 0;
    imem_req_ready = 1'b1;
    step(5);
    chk("t3_inflight", 64'(acc_cnt), 64'd2);
    redirect_to(64'h1003);
    rsp_en = 1'b1;
    xq.delete();
    wait_xfer(1, "t3_xfer");
    if (xq.size() > 0) begin
      chk("t3_pc", xq[0].pc, 64'h1000);
      chk("t3_inst", 64'(xq[0].inst), 64'(word_of(64'h1000)));
    end

    // 4: access fault on pc 0x8
    err_addr = 64'h8;
    redirect_to(64'h0);
    xq.delete();
    wait_xfer(3, "t4_xfers");
    if (xq.size() >= 3) begin
      chk("t4_pc0", xq[0].pc, 64'h0);
      chk("t4_fault0", 64'(xq[0].fault), 64'd0);
      chk("t4_pc8", xq[2].pc, 64'h8);
      chk("t4_fault8", 64'(xq[2].fault), 64'd1);
    end
    req_cnt = 0;
    step(6);
    chk("t4_no_req_in_fault", 64'(req_cnt), 64'd0);
    err_addr = '1;
    redirect_to(64'h40);
    xq.delete();
    wait_xfer(1, "t4_resume");
    if (xq.size() > 0) begin
      chk("t4_resume_pc", xq[0].pc, 64'h40);
      chk("t4_resume_fault", 64'(xq[0].fault), 64'd0);
    end

    // 5: request held while not ready; redirect coincides with a response
    imem_req_ready = 1'b0;
    step(6);
    a0      = imem_req_addr;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_addr_stable", imem_req_addr, a0);
      chk("t5_req_valid", 64'(imem_req_valid), 64'd1);
    end
    chk("t5_no_accept", 64'(acc_cnt), 64'd0);
    rsp_en         = 1'b0;
    imem_req_ready = 1'b1;
    step(1);
    imem_req_ready = 1'b0;
    step(1);
    chk("t5_one_accept", 64'(acc_cnt), 64'd1);
    rsp_en = 1'b1;
    redirect_to(64'h2000);
    imem_req_ready = 1'b1;
    xq.delete();
    wait_xfer(1, "t5_xfer");
    if (xq.size() > 0) chk("t5_pc", xq[0].pc, 64'h2000);

    // 6: reset with two outstanding, stray response afterwards
    imem_req_ready = 1'b0;
    step(6);
    rsp_en         = 1'b0;
    acc_cnt        = 0;
    imem_req_ready = 1'b1;
    step(5);
    chk("t6_inflight", 64'(acc_cnt), 64'd2);
    rst = 1'b1;
    step(1);
    rst         = 1'b0;
    stray_pulse = 1'b1;
    rsp_en      = 1'b1;
    check_reset_outputs("t6");
    xq.delete();
    wait_xfer(2, "t6_xfers");
    if (xq.size() >= 2) begin
      chk("t6_pc0", xq[0].pc, 64'h0);
      chk("t6_pc4", xq[1].pc, 64'h4);
      chk("t6_inst0", 64'(xq[0].inst), 64'(word_of(64'h0)));
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
